// File: rtl/data_mover_bram.sv
// data_mover_bram: streams N words out of BRAM0, splits each word into two
// byte-pair operands, multiplies each pair and writes both 16-bit products
// to BRAM1 at the same index. The datapath accepts one entry per cycle:
// read -> BRAM latency -> product register -> write.
module data_mover_bram #(
    parameter int CNT_BIT       = 31,
    parameter int DWIDTH        = 32,
    parameter int AWIDTH        = 12,
    parameter int MEM_SIZE      = 4096,
    parameter int IN_DATA_WITDH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_run,
    input  logic [CNT_BIT-1:0] i_num_cnt,
    output logic               o_idle,
    output logic               o_read,
    output logic               o_write,
    output logic               o_done,
    output logic [AWIDTH-1:0]  addr_b0,
    output logic               ce_b0,
    output logic               we_b0,
    input  logic [DWIDTH-1:0]  q_b0,
    output logic [DWIDTH-1:0]  d_b0,
    output logic [AWIDTH-1:0]  addr_b1,
    output logic               ce_b1,
    output logic               we_b1,
    input  logic [DWIDTH-1:0]  q_b1,
    output logic [DWIDTH-1:0]  d_b1
);

    localparam int W      = IN_DATA_WITDH;
    localparam int PW     = 2 * W;
    // stage 0: BRAM0 data valid, stage 1: products valid (write cycle)
    localparam int STAGES = 2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                          state_q;
    logic [CNT_BIT-1:0]              num_q;
    logic [CNT_BIT-1:0]              rd_cnt_q;
    logic [STAGES-1:0]               vld_pipe_q;
    logic [STAGES-1:0][AWIDTH-1:0]   idx_pipe_q;
    logic [PW-1:0]                   r0_q, r1_q;
    logic                            rd_fire;
    logic [W-1:0]                    a0, b0, a1, b1;

    // a read is issued every RUN cycle until all N indices have been requested
    assign rd_fire = (state_q == S_RUN) && (rd_cnt_q != num_q);

    assign a0 = q_b0[4*W-1:3*W];
    assign b0 = q_b0[3*W-1:2*W];
    assign a1 = q_b0[2*W-1:W];
    assign b1 = q_b0[W-1:0];

    // control FSM: captures N on start, counts issued reads, and leaves RUN
    // once every read is issued and the last one has left the BRAM stage
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q  <= S_IDLE;
            num_q    <= '0;
            rd_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_run) begin
                        num_q    <= i_num_cnt;
                        rd_cnt_q <= '0;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (rd_fire)
                        rd_cnt_q <= rd_cnt_q + CNT_BIT'(1);
                    // last write is on the wire this cycle; DONE follows it
                    if ((rd_cnt_q == num_q) && !vld_pipe_q[0])
                        state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // datapath pipeline: valid/index shift registers and registered products
    always_ff @(posedge clk) begin
        if (reset_n) begin
            vld_pipe_q <= '0;
            idx_pipe_q <= '0;
            r0_q       <= '0;
            r1_q       <= '0;
        end else begin
            vld_pipe_q    <= {vld_pipe_q[0], rd_fire};
            idx_pipe_q[0] <= rd_cnt_q[AWIDTH-1:0];
            idx_pipe_q[1] <= idx_pipe_q[0];
            if (vld_pipe_q[0]) begin
                r0_q <= {{W{1'b0}}, a0} * {{W{1'b0}}, b0};
                r1_q <= {{W{1'b0}}, a1} * {{W{1'b0}}, b1};
            end
        end
    end

    assign o_idle  = (state_q == S_IDLE);
    assign o_done  = (state_q == S_DONE);
    assign o_read  = rd_fire;
    assign o_write = vld_pipe_q[1];

    // BRAM0 is read-only from this block
    assign addr_b0 = rd_cnt_q[AWIDTH-1:0];
    assign ce_b0   = rd_fire;
    assign we_b0   = 1'b0;
    assign d_b0    = '0;

    // BRAM1 is write-only from this block
    assign addr_b1 = idx_pipe_q[1];
    assign ce_b1   = vld_pipe_q[1];
    assign we_b1   = vld_pipe_q[1];
    assign d_b1    = DWIDTH'({r0_q, r1_q});

    // BRAM1 read data and the depth parameter have no role in this block
    logic unused_ok;
    assign unused_ok = (^q_b1) | (MEM_SIZE == 0);

endmodule

// File: tb/tb_data_mover_bram.sv
// Bench for data_mover_bram: BRAM models around the DUT, a negedge monitor
// that logs BRAM1 writes and run activity, and per-scenario tasks that push
// expected writes into a scoreboard queue and pop them against the log.
module tb_data_mover_bram;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MS = 4096;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          i_run = 1'b0;
    logic [30:0]   i_num_cnt = '0;
    logic          o_idle, o_read, o_write, o_done;
    logic [AW-1:0] addr_b0, addr_b1;
    logic          ce_b0, we_b0, ce_b1, we_b1;
    logic [DW-1:0] q_b0, d_b0, d_b1;
    logic [DW-1:0] q_b1 = 32'hDEADBEEF;

    data_mover_bram dut (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_cnt(i_num_cnt),
        .o_idle(o_idle), .o_read(o_read), .o_write(o_write), .o_done(o_done),
        .addr_b0(addr_b0), .ce_b0(ce_b0), .we_b0(we_b0), .q_b0(q_b0), .d_b0(d_b0),
        .addr_b1(addr_b1), .ce_b1(ce_b1), .we_b1(we_b1), .q_b1(q_b1), .d_b1(d_b1)
    );

    always #5 clk = ~clk;

    // BRAM models: one-cycle read latency on BRAM0, write-only use of BRAM1
    logic [DW-1:0] mem0 [MS];
    logic [DW-1:0] mem1 [MS];
    always @(posedge clk) begin
        if (ce_b0) q_b0 <= mem0[addr_b0];
        if (ce_b1 && we_b1) mem1[addr_b1] <= d_b1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];   // scoreboard, owned by the test tasks
    wr_t obs_q[$];   // write log, owned by the monitor
    int  obs_rd = 0;

    int n_checks = 0;
    int n_fail   = 0;

    // monitor state
    bit            mon_en = 1'b0;
    int            n_rd = 0, n_done = 0, last_done = -1;
    int            rd_first = -1, rd_last = -1, bad_rd = 0, bad_proto = 0;
    logic          prev_rd = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (ce_b1 && we_b1) obs_q.push_back('{cyc, addr_b1, d_b1});
            if (ce_b0) begin
                n_rd    <= n_rd + 1;
                rd_last <= cyc;
                if (!prev_rd) rd_first <= cyc;
                if (addr_b0 !== (prev_rd ? prev_addr + 12'd1 : 12'd0)) bad_rd <= bad_rd + 1;
            end
            prev_rd   <= ce_b0;
            prev_addr <= addr_b0;
            if (o_done) begin
                n_done    <= n_done + 1;
                last_done <= cyc;
            end
            if (we_b0 !== 1'b0 || d_b0 !== '0 || o_read !== ce_b0 || o_write !== ce_b1 ||
                we_b1 !== ce_b1 || (o_idle && (o_read || o_write || o_done)))
                bad_proto <= bad_proto + 1;
        end
    end

    function automatic logic [31:0] model(input logic [31:0] w);
        logic [15:0] a0, b0, a1, b1;
        a0 = 16'(w[31:24]); b0 = 16'(w[23:16]);
        a1 = 16'(w[15:8]);  b1 = 16'(w[7:0]);
        return {a0 * b0, a1 * b1};
    endfunction

    // stimulus only: pulse i_run; t is the cycle carrying read index 0
    task automatic start_run(input int n, output int t);
        @(negedge clk);
        i_num_cnt = 31'(n);
        i_run     = 1'b1;
        @(posedge clk);
        #1;
        i_run = 1'b0;
        t     = cyc;
    endtask

    task automatic wait_done(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (n_done != base) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({o_idle, o_read, o_write, o_done} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags: got idle/read/write/done=%b, expected 1000", {o_idle, o_read, o_write, o_done});
        end
        n_checks++;
        if ({ce_b0, we_b0, ce_b1, we_b1} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_bram_ctl: got ce0/we0/ce1/we1=%b, expected 0000", {ce_b0, we_b0, ce_b1, we_b1});
        end
        reset_n = 1'b0;
        mon_en  = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({o_idle, o_read, o_write, o_done, ce_b0, ce_b1} !== 6'b100000) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b, expected 100000", {o_idle, o_read, o_write, o_done, ce_b0, ce_b1});
        end
    endtask

    task automatic test_single(input logic [31:0] word, input logic [31:0] expv, input string tag);
        int t; bit ok; int bd; wr_t e, o;
        bd = n_done;
        mem0[0] = word;
        start_run(1, t);
        exp_q.push_back('{t + 2, 12'd0, expv});
        wait_done(bd, 20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL %s done_timeout: got no o_done, expected one", tag); end
        n_checks++;
        if (last_done != t + 3) begin n_fail++; $display("FAIL %s done_cycle: got %0d, expected %0d", tag, last_done, t + 3); end
        repeat (exp_q.size()) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_rd >= obs_q.size()) begin n_fail++; $display("FAIL %s write_missing: expected addr %0d data %08h", tag, e.addr, e.data); end
            else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.addr !== e.addr || o.data !== e.data || o.cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL %s write: got addr %0d data %08h cyc %0d, expected addr %0d data %08h cyc %0d", tag, o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != obs_rd) begin n_fail++; $display("FAIL %s extra_writes: got %0d, expected 0", tag, obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
        @(negedge clk);
        n_checks++;
        if (mem1[0] !== expv) begin n_fail++; $display("FAIL %s bram1_word: got %08h, expected %08h", tag, mem1[0], expv); end
        n_checks++;
        if (o_idle !== 1'b1) begin n_fail++; $display("FAIL %s back_to_idle: got %b, expected 1", tag, o_idle); end
    endtask

    task automatic test_full_stream();
        int t; bit ok; int bd, br, bb; wr_t e, o;
        bd = n_done; br = n_rd; bb = bad_rd;
        for (int k = 0; k < MS; k++) mem0[k] = $urandom;
        start_run(MS, t);
        for (int k = 0; k < MS; k++) exp_q.push_back('{t + 2 + k, 12'(k), model(mem0[k])});
        wait_done(bd, MS + 50, ok);
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL full done_timeout: got no o_done, expected one"); end
        n_checks++;
        if (last_done != t + MS + 2) begin n_fail++; $display("FAIL full done_cycle: got %0d, expected %0d", last_done, t + MS + 2); end
        n_checks++;
        if (n_done - bd != 1) begin n_fail++; $display("FAIL full done_pulses: got %0d, expected 1", n_done - bd); end
        n_checks++;
        if (n_rd - br != MS || rd_first != t || rd_last != t + MS - 1) begin
            n_fail++;
            $display("FAIL full reads: got count %0d first %0d last %0d, expected %0d %0d %0d", n_rd - br, rd_first, rd_last, MS, t, t + MS - 1);
        end
        n_checks++;
        if (bad_rd != bb) begin n_fail++; $display("FAIL full read_addr_seq: got %0d bad, expected 0", bad_rd - bb); end
        repeat (exp_q.size()) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_rd >= obs_q.size()) begin n_fail++; $display("FAIL full write_missing: expected addr %0d data %08h", e.addr, e.data); end
            else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.addr !== e.addr || o.data !== e.data || o.cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL full write: got addr %0d data %08h cyc %0d, expected addr %0d data %08h cyc %0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != obs_rd) begin n_fail++; $display("FAIL full extra_writes: got %0d, expected 0", obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
    endtask

    task automatic test_zero_count();
        int t; bit ok; int bd, br;
        bd = n_done; br = n_rd;
        start_run(0, t);
        wait_done(bd, 20, ok);
        n_checks++;
        if (!ok || last_done != t + 1) begin n_fail++; $display("FAIL zero done_cycle: got %0d, expected %0d", last_done, t + 1); end
        @(negedge clk);
        n_checks++;
        if (o_idle !== 1'b1) begin n_fail++; $display("FAIL zero back_to_idle: got %b, expected 1", o_idle); end
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (n_rd != br || obs_q.size() != obs_rd) begin
            n_fail++;
            $display("FAIL zero bram_activity: got reads %0d writes %0d, expected 0 0", n_rd - br, obs_q.size() - obs_rd);
            obs_rd = obs_q.size();
        end
    endtask

    task automatic test_back_to_back();
        int t; bit ok; int bd, br; wr_t e, o;
        bd = n_done; br = n_rd;
        for (int k = 0; k < 8; k++) mem0[k] = $urandom;
        start_run(8, t);
        for (int k = 0; k < 8; k++) exp_q.push_back('{t + 2 + k, 12'(k), model(mem0[k])});
        while (cyc != t + 3) @(negedge clk);
        i_num_cnt = 31'd20;
        i_run     = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
        wait_done(bd, 60, ok);
        repeat (30) @(negedge clk);
        #1;
        n_checks++;
        if (!ok || last_done != t + 10) begin n_fail++; $display("FAIL rerun done_cycle: got %0d, expected %0d", last_done, t + 10); end
        n_checks++;
        if (n_done - bd != 1 || n_rd - br != 8) begin
            n_fail++;
            $display("FAIL rerun counts: got done %0d reads %0d, expected 1 8", n_done - bd, n_rd - br);
        end
        repeat (exp_q.size()) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_rd >= obs_q.size()) begin n_fail++; $display("FAIL rerun write_missing: expected addr %0d data %08h", e.addr, e.data); end
            else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.addr !== e.addr || o.data !== e.data || o.cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL rerun write: got addr %0d data %08h cyc %0d, expected addr %0d data %08h cyc %0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != obs_rd) begin n_fail++; $display("FAIL rerun extra_writes: got %0d, expected 0", obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
    endtask

    task automatic test_reset_mid_run();
        int t; bit ok; int bd; wr_t e, o;
        bd = n_done;
        for (int k = 0; k < 16; k++) mem0[k] = $urandom;
        start_run(16, t);
        // writes for indices 0..4 land in cycles t+2..t+6 before the reset edge
        for (int k = 0; k < 5; k++) exp_q.push_back('{t + 2 + k, 12'(k), model(mem0[k])});
        while (cyc != t + 6) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_idle !== 1'b1 || ce_b1 !== 1'b0 || o_write !== 1'b0) begin
            n_fail++;
            $display("FAIL abort idle: got idle %b ce_b1 %b write %b, expected 1 0 0", o_idle, ce_b1, o_write);
        end
        reset_n = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        n_checks++;
        if (n_done != bd) begin n_fail++; $display("FAIL abort done_pulses: got %0d, expected 0", n_done - bd); end
        // fresh run after the abort
        for (int k = 0; k < 3; k++) mem0[k] = $urandom;
        start_run(3, t);
        for (int k = 0; k < 3; k++) exp_q.push_back('{t + 2 + k, 12'(k), model(mem0[k])});
        wait_done(bd, 30, ok);
        n_checks++;
        if (!ok || last_done != t + 5) begin n_fail++; $display("FAIL abort rerun_done: got %0d, expected %0d", last_done, t + 5); end
        repeat (3) @(negedge clk);
        #1;
        repeat (exp_q.size()) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_rd >= obs_q.size()) begin n_fail++; $display("FAIL abort write_missing: expected addr %0d data %08h", e.addr, e.data); end
            else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.addr !== e.addr || o.data !== e.data || o.cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL abort write: got addr %0d data %08h cyc %0d, expected addr %0d data %08h cyc %0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != obs_rd) begin n_fail++; $display("FAIL abort extra_writes: got %0d, expected 0", obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
    endtask

    initial begin
        test_reset();
        test_single(32'h03040506, 32'h000C001E, "basic");
        test_single(32'hFFFFFFFF, 32'hFE01FE01, "max");
        test_zero_count();
        test_back_to_back();
        test_full_stream();
        test_reset_mid_run();
        #1;
        n_checks++;
        if (bad_proto != 0) begin n_fail++; $display("FAIL protocol: got %0d bad cycles, expected 0", bad_proto); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mover_bram.md
DATA_MOVER_BRAM -- requirements
Module: data_mover_bram

Interface
REQ-001 SHALL have parameter CNT_BIT, default 31, width of the entry-count input.
REQ-002 SHALL have parameter DWIDTH, default 32, width of the BRAM data word.
REQ-003 SHALL have parameter AWIDTH, default 12, width of the BRAM address.
REQ-004 SHALL have parameter MEM_SIZE, default 4096, depth of each BRAM.
REQ-005 SHALL have parameter IN_DATA_WITDH, default 8, width of each multiplier operand.
REQ-006 SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-007 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-008 SHALL have port reset_n, input, 1 bit: synchronous reset, asserted when 1, despite the name suffix.
REQ-009 SHALL have port i_run, input, 1 bit: start pulse.
REQ-010 SHALL have port i_num_cnt, input, CNT_BIT bits: number of entries to process.
REQ-011 SHALL have port o_idle, output, 1 bit: high in IDLE.
REQ-012 SHALL have port o_read, output, 1 bit: high while BRAM0 reads are issued.
REQ-013 SHALL have port o_write, output, 1 bit: high while BRAM1 writes are issued.
REQ-014 SHALL have port o_done, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have the source BRAM0 port: addr_b0 output AWIDTH; ce_b0 output 1; we_b0 output 1; q_b0 input DWIDTH; d_b0 output DWIDTH.
REQ-016 SHALL have the destination BRAM1 port: addr_b1 output AWIDTH; ce_b1 output 1; we_b1 output 1; q_b1 input DWIDTH (unused); d_b1 output DWIDTH.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DONE.
REQ-018 SHALL move from IDLE to RUN when i_run=1, capturing i_num_cnt as N.
REQ-019 SHALL ignore i_run outside IDLE.
REQ-020 SHALL, in RUN, issue N reads to BRAM0, one per cycle, at addresses 0..N-1 with ce_b0=1 and we_b0=0; o_read=1 on those cycles.
REQ-021 SHALL assume BRAM read latency of 1 cycle: q_b0 is valid the cycle after the address and ce are driven.
REQ-022 SHALL split each source word as q_b0 = {a0[31:24], b0[23:16], a1[15:8], b1[7:0]}.
REQ-023 SHALL compute two independent unsigned products, r0=a0*b0 and r1=a1*b1, each 16 bits, with no overflow possible; both products SHALL be registered.
REQ-024 SHALL write d_b1={r0,r1} (r0 in [31:16], r1 in [15:0]) to BRAM1 at the same index k as the source read, with ce_b1=we_b1=1 and o_write=1 on write cycles.
REQ-025 SHALL, for a run started by i_run sampled high at edge T, drive the read for index k in cycle T+1+k and the write for index k in cycle T+3+k; the pipeline is fully streaming, one entry per cycle.
REQ-026 SHALL enter DONE after the write for index N-1 is issued, assert o_done=1 for exactly one cycle (cycle T+3+N), then return to IDLE.
REQ-027 SHALL, when N=0, go from RUN directly to DONE with no reads or writes; o_done SHALL be high in cycle T+2.
REQ-028 SHALL generate addresses as index[AWIDTH-1:0], so indices at or above 2^AWIDTH wrap.
REQ-029 SHALL drive d_b0 to 0 and we_b0 to 0 at all times, and SHALL never read q_b1.
REQ-030 SHALL hold ce_b0, ce_b1 and we_b1 at 0 whenever no access is being issued.
REQ-031 SHALL drive o_idle=1 only in IDLE.
REQ-032 SHALL drive o_read, o_write and o_done only from FSM/pipeline state; each SHALL be 0 in IDLE.

Reset
REQ-033 SHALL, with reset_n=1 at a clock edge, set the FSM to IDLE and clear counters and pipeline valid bits.
REQ-034 SHALL, after reset, hold o_idle=1, o_read=o_write=o_done=0 and all ce/we=0.
REQ-035 SHALL, on reset during RUN, abort the run immediately; entries already written remain in BRAM1, and no further writes occur.

Verification
REQ-036 SHALL pass this test: BRAM0[0]=0x03040506, N=1, i_run pulse -> BRAM1[0]=0x000C001E, and o_done pulses 4 cycles after the i_run edge.
REQ-037 SHALL pass this test: BRAM0[0]=0xFFFFFFFF, N=1 -> BRAM1[0]=0xFE01FE01.
REQ-038 SHALL pass this test: N=4096 random words -> for every k, BRAM1[k][31:16]=a0*b0 and BRAM1[k][15:0]=a1*b1; o_read high for 4096 consecutive cycles, o_write high for 4096 consecutive cycles, and o_done 1 cycle.
REQ-039 SHALL pass this test: N=0 -> no ce_b0/ce_b1 activity, o_done at T+2, then o_idle=1.
REQ-040 SHALL pass this test: i_run re-pulsed mid-run with N=8 -> ignored; exactly 8 writes occur and one o_done pulse.
REQ-041 SHALL pass this test: reset_n=1 asserted mid-run at N=16 -> next cycle o_idle=1 and no further BRAM1 writes; a new run then completes correctly.
